// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: stage indices, width helper and prefix-mask encoder shared by the hazard controller
package pipe_hazard_ctrl_pkg;
  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB = 4;
  localparam int DEF_STAGES = 5;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // bits 0..idx set; used for both the stall prefix and the flush mask
  function automatic logic [31:0] thermo(input int idx);
    logic [31:0] t;
    for (int i = 0; i < 32; i++) t[i] = (i <= idx);
    return t;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: request/response bundle between the core pipeline and the hazard controller
interface pipe_hazard_ctrl_if import pipe_hazard_ctrl_pkg::*; #(
  parameter int NUM_STAGES = DEF_STAGES,
  parameter int NUM_REQ = 3,
  parameter int CNT_W = 32,
  parameter int SW = clog2(NUM_STAGES)
) ();
  logic rdy_in;
  logic [NUM_REQ*NUM_STAGES-1:0] stall_req_in;
  logic flush_valid_in;
  logic [SW-1:0] flush_stage_in;
  logic [NUM_STAGES-1:0] stall_out;
  logic [NUM_STAGES-1:0] bubble_out;
  logic [NUM_STAGES-1:0] flush_out;
  logic [CNT_W-1:0] stall_cycles_out;
  logic wdog_err_out;
  modport master (
    output rdy_in, stall_req_in, flush_valid_in, flush_stage_in,
    input stall_out, bubble_out, flush_out, stall_cycles_out, wdog_err_out
  );
  modport slave (
    input rdy_in, stall_req_in, flush_valid_in, flush_stage_in,
    output stall_out, bubble_out, flush_out, stall_cycles_out, wdog_err_out
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// pipe_hazard_ctrl_sat_counter: saturating up-counter with synchronous clear
module pipe_hazard_ctrl_sat_counter #(
  parameter int W = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic i_inc,
  input  logic i_clr,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_inc && o_q != MAX) o_q <= o_q + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: merges stall requests into a prefix stall, inserts bubbles, stretches flushes, counts stalls
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
  parameter int NUM_STAGES = DEF_STAGES,
  parameter int NUM_REQ = 3,
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input logic clk_in,
  input logic rst_n_in,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int SW = clog2(NUM_STAGES);
  logic [NUM_STAGES-1:0] w_req, w_stall_raw, w_bub_raw, w_fmask, w_flush, w_stall, w_bub;
  logic [SW-1:0] w_deep, w_fs;
  logic w_any, w_acc;
  logic [3:0] r_cnt;
  logic [NUM_STAGES-1:0] r_mask;
  logic [15:0] w_wcnt;
  logic r_wdog;
  always_comb begin
    w_req = '0;
    w_deep = '0;
    for (int r = 0; r < NUM_REQ; r++) w_req = w_req | bus.stall_req_in[r*NUM_STAGES +: NUM_STAGES];
    for (int s = 0; s < NUM_STAGES; s++) if (w_req[s]) w_deep = SW'(s);
  end
  assign w_any = |w_req;
  assign w_stall_raw = w_any ? NUM_STAGES'(thermo(int'(w_deep))) : '0;
  // the bubble sits just above the top of the stall prefix; it falls off the end for the oldest stage
  assign w_bub_raw = (w_stall_raw << 1) & ~w_stall_raw;
  assign w_fs = (int'(bus.flush_stage_in) > NUM_STAGES - 1) ? SW'(NUM_STAGES - 1) : bus.flush_stage_in;
  assign w_fmask = NUM_STAGES'(thermo(int'(w_fs)));
  assign w_acc = bus.flush_valid_in & bus.rdy_in;
  assign w_flush = bus.rdy_in ? ((r_cnt != 4'd0 ? r_mask : '0) | (w_acc ? w_fmask : '0)) : '0;
  assign w_stall = bus.rdy_in ? (w_stall_raw & ~w_flush) : '1;
  assign w_bub = bus.rdy_in ? (w_bub_raw & ~w_flush) : '0;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      r_cnt <= '0;
      r_mask <= '0;
    end else if (w_acc) begin
      r_cnt <= 4'(FLUSH_LEN - 1);
      r_mask <= w_flush;
    end else if (bus.rdy_in && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
      r_mask <= r_cnt == 4'd1 ? '0 : r_mask;
    end
  pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_cyc (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .i_inc(bus.rdy_in & w_stall[STG_IF]),
    .i_clr(1'b0), .o_q(bus.stall_cycles_out)
  );
  pipe_hazard_ctrl_sat_counter #(.W(16), .MAX(16'(WDOG_LIMIT))) u_wdog (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .i_inc(bus.rdy_in & w_any),
    .i_clr(bus.rdy_in & ~w_any), .o_q(w_wcnt)
  );
  // set on the edge that brings the count to the limit, not one later
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) r_wdog <= 1'b0;
    else r_wdog <= r_wdog | (bus.rdy_in & w_any & (w_wcnt >= 16'(WDOG_LIMIT - 1)));
  assign bus.stall_out = rst_n_in ? w_stall : '0;
  assign bus.bubble_out = rst_n_in ? w_bub : '0;
  assign bus.flush_out = rst_n_in ? w_flush : '0;
  assign bus.wdog_err_out = r_wdog;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector bench for the stall/flush controller
module tb_pipe_hazard_ctrl;
  typedef struct {
    logic rdy;
    logic [14:0] req;
    logic [4:0] stall;
    logic [4:0] bub;
  } vec_t;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vt[8];
  always #5 clk_in = ~clk_in;
  pipe_hazard_ctrl_if #(.NUM_STAGES(5), .NUM_REQ(3), .CNT_W(32)) ifa ();
  pipe_hazard_ctrl_if #(.NUM_STAGES(5), .NUM_REQ(3), .CNT_W(3)) ifb ();
  assign ifb.rdy_in = ifa.rdy_in;
  assign ifb.stall_req_in = ifa.stall_req_in;
  assign ifb.flush_valid_in = ifa.flush_valid_in;
  assign ifb.flush_stage_in = ifa.flush_stage_in;
  pipe_hazard_ctrl #(.NUM_STAGES(5), .NUM_REQ(3), .FLUSH_LEN(2), .CNT_W(32), .WDOG_LIMIT(8)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(ifa)
  );
  pipe_hazard_ctrl #(.NUM_STAGES(5), .NUM_REQ(3), .FLUSH_LEN(2), .CNT_W(3), .WDOG_LIMIT(8)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(ifb)
  );
  task automatic chk5(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic drive(input logic rdy, input logic [14:0] req, input logic fv, input logic [2:0] fs);
    ifa.rdy_in = rdy;
    ifa.stall_req_in = req;
    ifa.flush_valid_in = fv;
    ifa.flush_stage_in = fs;
  endtask
  task automatic outs(input string nm, input logic [4:0] st, input logic [4:0] bu, input logic [4:0] fl);
    chk5({nm, " stall"}, ifa.stall_out, st);
    chk5({nm, " bubble"}, ifa.bubble_out, bu);
    chk5({nm, " flush"}, ifa.flush_out, fl);
  endtask
  task automatic do_reset();
    @(posedge clk_in);
    #1 rst_n_in = 1'b0;
    drive(1'b1, '0, 1'b0, 3'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask
  initial begin
    vt[0] = '{1'b1, {5'b00000, 5'b00000, 5'b00000}, 5'b00000, 5'b00000};
    vt[1] = '{1'b1, {5'b01000, 5'b00000, 5'b00010}, 5'b01111, 5'b10000};
    vt[2] = '{1'b1, {5'b10000, 5'b00000, 5'b00000}, 5'b11111, 5'b00000};
    vt[3] = '{1'b1, {5'b00000, 5'b00000, 5'b00001}, 5'b00001, 5'b00010};
    vt[4] = '{1'b1, {5'b00100, 5'b00001, 5'b00000}, 5'b00111, 5'b01000};
    vt[5] = '{1'b1, {5'b00000, 5'b00011, 5'b00000}, 5'b00011, 5'b00100};
    vt[6] = '{1'b0, {5'b00000, 5'b00000, 5'b00001}, 5'b11111, 5'b00000};
    vt[7] = '{1'b1, {5'b00000, 5'b10000, 5'b00001}, 5'b11111, 5'b00000};
    drive(1'b1, {5'b00001, 5'b00100, 5'b10000}, 1'b1, 3'd3);
    #1 rst_n_in = 1'b0;
    #2;
    outs("reset_imm", 5'b0, 5'b0, 5'b0);
    chk32("reset_imm cycles", ifa.stall_cycles_out, 32'd0);
    chk32("reset_imm wdog", 32'(ifa.wdog_err_out), 32'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    outs("reset_hold", 5'b0, 5'b0, 5'b0);
    chk32("reset_hold cycles_b", 32'(ifb.stall_cycles_out), 32'd0);
    drive(1'b1, '0, 1'b0, 3'd0);
    rst_n_in = 1'b1;
    drive(1'b1, {5'b00000, 5'b00100, 5'b00000}, 1'b0, 3'd0);
    #2;
    outs("req1_bit2", 5'b00111, 5'b01000, 5'b00000);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_in);
      #1 drive(vt[i].rdy, vt[i].req, 1'b0, 3'd0);
      @(negedge clk_in);
      outs($sformatf("vec%0d", i), vt[i].stall, vt[i].bub, 5'b00000);
    end
    do_reset();
    drive(1'b1, 15'b00000_00000_00001, 1'b1, 3'd1);
    @(negedge clk_in);
    outs("flush_T", 5'b00000, 5'b00000, 5'b00011);
    @(posedge clk_in);
    #1 drive(1'b1, 15'b00000_00000_00001, 1'b0, 3'd0);
    @(negedge clk_in);
    outs("flush_T1", 5'b00000, 5'b00000, 5'b00011);
    @(negedge clk_in);
    outs("flush_T2", 5'b00001, 5'b00010, 5'b00000);
    @(posedge clk_in);
    #1 drive(1'b1, 15'b00000_00000_00001, 1'b1, 3'd7);
    @(negedge clk_in);
    outs("clamp_T", 5'b00000, 5'b00000, 5'b11111);
    @(posedge clk_in);
    #1 drive(1'b1, 15'b00000_00000_00001, 1'b0, 3'd0);
    @(negedge clk_in);
    chk5("clamp_T1 flush", ifa.flush_out, 5'b11111);
    @(negedge clk_in);
    chk5("clamp_T2 flush", ifa.flush_out, 5'b00000);
    @(posedge clk_in);
    #1 drive(1'b1, '0, 1'b1, 3'd1);
    @(negedge clk_in);
    chk5("ovl_T flush", ifa.flush_out, 5'b00011);
    @(posedge clk_in);
    #1 drive(1'b1, '0, 1'b1, 3'd3);
    @(negedge clk_in);
    chk5("ovl_T1 flush", ifa.flush_out, 5'b01111);
    @(posedge clk_in);
    #1 drive(1'b1, '0, 1'b0, 3'd0);
    @(negedge clk_in);
    chk5("ovl_T2 flush", ifa.flush_out, 5'b01111);
    @(negedge clk_in);
    chk5("ovl_T3 flush", ifa.flush_out, 5'b00000);
    do_reset();
    drive(1'b1, 15'b00000_00000_00001, 1'b1, 3'd2);
    @(negedge clk_in);
    outs("frz_T", 5'b00000, 5'b00000, 5'b00111);
    @(posedge clk_in);
    #1 drive(1'b0, 15'b00000_00000_00001, 1'b1, 3'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      outs($sformatf("frz_%0d", k), 5'b11111, 5'b00000, 5'b00000);
      chk32($sformatf("frz_%0d cycles", k), ifa.stall_cycles_out, 32'd0);
    end
    @(posedge clk_in);
    #1 drive(1'b1, 15'b00000_00000_00001, 1'b0, 3'd0);
    @(negedge clk_in);
    outs("frz_resume", 5'b00000, 5'b00000, 5'b00111);
    chk32("frz_resume cycles", ifa.stall_cycles_out, 32'd0);
    @(negedge clk_in);
    outs("frz_done", 5'b00001, 5'b00010, 5'b00000);
    @(negedge clk_in);
    chk32("frz_count", ifa.stall_cycles_out, 32'd1);
    chk32("frz_count_b", 32'(ifb.stall_cycles_out), 32'd1);
    do_reset();
    drive(1'b1, 15'b00000_00000_00001, 1'b0, 3'd0);
    repeat (7) @(posedge clk_in);
    @(negedge clk_in);
    chk32("wdog7 err", 32'(ifa.wdog_err_out), 32'd0);
    chk32("wdog7 cycles", ifa.stall_cycles_out, 32'd7);
    chk32("wdog7 cycles_b", 32'(ifb.stall_cycles_out), 32'd7);
    @(posedge clk_in);
    #1 drive(1'b1, '0, 1'b0, 3'd0);
    @(negedge clk_in);
    chk32("wdog8 err", 32'(ifa.wdog_err_out), 32'd1);
    chk32("wdog8 cycles", ifa.stall_cycles_out, 32'd8);
    chk32("wdog8 cycles_b sat", 32'(ifb.stall_cycles_out), 32'd7);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk32("wdog sticky", 32'(ifa.wdog_err_out), 32'd1);
    chk32("wdog idle cycles", ifa.stall_cycles_out, 32'd8);
    chk32("idle cycles_b sat", 32'(ifb.stall_cycles_out), 32'd7);
    outs("idle", 5'b00000, 5'b00000, 5'b00000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
